// File: rtl/mem_arb_pkg.sv
// Shared types and lane constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Index by size: element 0 is the single-byte enable.
    localparam logic [3:0][7:0] BE_LUT = {8'hFF, 8'h0F, 8'h03, 8'h01};

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 64'h0000_0000_0000_00FF;
            SZ_H:    return 64'h0000_0000_0000_FFFF;
            SZ_W:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 64-bit memory: byte enables, store shift, load extract, misalignment.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [2:0]  offset_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  be_o,
    output logic [63:0] wdata_o,
    output logic [63:0] rdata_o,
    output logic        misalign_o
);

    logic [5:0] bit_sh;

    assign bit_sh  = {offset_i, 3'b000};
    assign be_o    = BE_LUT[size_i] << offset_i;
    assign wdata_o = wdata_i << bit_sh;
    assign rdata_o = (rdata_i >> bit_sh) & size_mask(size_i);

    always_comb begin
        misalign_o = 1'b0;
        case (size_i)
            SZ_B:    misalign_o = 1'b0;
            SZ_H:    misalign_o = offset_i[0];
            SZ_W:    misalign_o = |offset_i[1:0];
            default: misalign_o = |offset_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and load/store, one access at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 15,
    parameter int FAIR    = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic [31:0]       if_rdata_o,
    output logic              if_valid_o,
    output logic              if_err_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [1:0]        d_size_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_valid_o,
    output logic              d_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              busy_o
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d, last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d, err_q, err_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              idle, done, pick_d;
    logic [1:0]        al_size;
    logic [2:0]        al_off;
    logic [7:0]        al_be;
    logic [63:0]       al_wdata, al_rdata;
    logic              al_mis;

    assign idle = (state_q == IDLE);
    assign done = (state_q == DONE);

    // On a tie, fairness hands the port to whichever side did not own it last.
    assign pick_d   = d_req_i & (!if_req_i || FAIR == 0 || last_q == OWN_IF);
    assign d_gnt_o  = idle & pick_d;
    assign if_gnt_o = idle & if_req_i & !pick_d;

    // In IDLE the aligner checks the incoming data request; afterwards it serves the latched one.
    assign al_size = idle ? d_size_i      : size_q;
    assign al_off  = idle ? d_addr_i[2:0] : addr_q[2:0];

    mem_lane_align u_align (
        .size_i     (al_size),
        .offset_i   (al_off),
        .wdata_i    (wdata_q),
        .rdata_i    (rdata_q),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_mis)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (d_gnt_o || if_gnt_o) begin
                    owner_d = d_gnt_o ? OWN_D : OWN_IF;
                    last_d  = owner_d;
                    addr_d  = d_gnt_o ? d_addr_i  : if_addr_i;
                    we_d    = d_gnt_o ? d_we_i    : 1'b0;
                    size_d  = d_gnt_o ? d_size_i  : SZ_D;
                    wdata_d = d_gnt_o ? d_wdata_i : '0;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = d_gnt_o ? al_mis : (|if_addr_i[1:0]);
                    state_d = err_d ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            last_q  <= OWN_D;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o      = !idle;
    assign mem_req_o   = (state_q == ACCESS);
    assign mem_we_o    = mem_req_o & we_q;
    assign mem_addr_o  = mem_req_o ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign mem_be_o    = !mem_req_o ? 8'h00 : (owner_q == OWN_IF) ? 8'hFF : al_be;
    assign mem_wdata_o = mem_req_o ? al_wdata : '0;

    assign if_valid_o = done & (owner_q == OWN_IF);
    assign if_err_o   = if_valid_o & err_q;
    assign if_rdata_o = !if_valid_o ? 32'h0 : addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];

    assign d_valid_o = done & (owner_q == OWN_D);
    assign d_err_o   = d_valid_o & err_q;
    assign d_rdata_o = d_valid_o ? al_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a FAIR=1 and a FAIR=0 instance driven with the same stimulus.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ready;
    logic [63:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [1:0]  d_size;

    logic        if_gnt, if_valid, if_err, d_gnt, d_valid, d_err, mem_req, mem_we, busy;
    logic [31:0] if_rdata;
    logic [63:0] d_rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_be;

    logic        f0_if_gnt, f0_if_valid, f0_if_err, f0_d_gnt, f0_d_valid, f0_d_err;
    logic        f0_mem_req, f0_mem_we, f0_busy;
    logic [31:0] f0_if_rdata;
    logic [63:0] f0_d_rdata, f0_mem_addr, f0_mem_wdata;
    logic [7:0]  f0_mem_be;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(15), .FAIR(1)) dut (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_rdata_o(if_rdata),
        .if_valid_o(if_valid), .if_err_o(if_err),
        .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rdata_o(d_rdata), .d_valid_o(d_valid), .d_err_o(d_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .busy_o(busy)
    );

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(15), .FAIR(0)) dut_f0 (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(f0_if_gnt), .if_rdata_o(f0_if_rdata),
        .if_valid_o(f0_if_valid), .if_err_o(f0_if_err),
        .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(f0_d_gnt), .d_rdata_o(f0_d_rdata), .d_valid_o(f0_d_valid), .d_err_o(f0_d_err),
        .mem_req_o(f0_mem_req), .mem_we_o(f0_mem_we), .mem_addr_o(f0_mem_addr), .mem_be_o(f0_mem_be),
        .mem_wdata_o(f0_mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .busy_o(f0_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each cycle starts 1 time unit after the rising edge; inputs change there, checks follow #1.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; if_req = 0; d_req = 0; d_we = 0; d_size = 0; mem_ready = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        cyc(); cyc();
        reset = 1'b0;

        // simultaneous requests, three rounds
        for (int k = 0; k < 3; k++) begin
            cyc();
            if_req = 1; d_req = 1; if_addr = 64'h80; d_addr = 64'h40; d_size = 2'd3; d_we = 0;
            #1;
            chk("tie_if_gnt", if_gnt, (k != 1));
            chk("tie_d_gnt", d_gnt, (k == 1));
            chk("tie_f0_d_gnt", f0_d_gnt, 1);
            chk("tie_f0_if_gnt", f0_if_gnt, 0);
            cyc();
            if_req = 0; d_req = 0; mem_ready = 1;
            #1;
            chk("tie_mem_req", mem_req, 1);
            cyc();
            mem_ready = 0;
            #1;
            chk("tie_if_valid", if_valid, (k != 1));
            chk("tie_d_valid", d_valid, (k == 1));
            chk("tie_f0_d_valid", f0_d_valid, 1);
        end

        // fetch 0x10, ready on second ACCESS cycle
        cyc();
        if_req = 1; if_addr = 64'h10;
        #1;
        chk("fetch_gnt", if_gnt, 1);
        chk("fetch_d_gnt", d_gnt, 0);
        cyc();
        if_req = 0;
        #1;
        chk("fetch_mem_req", mem_req, 1);
        chk("fetch_mem_addr", mem_addr, 64'h10);
        chk("fetch_mem_be", mem_be, 8'hFF);
        chk("fetch_mem_we", mem_we, 0);
        chk("fetch_no_regnt", if_gnt, 0);
        cyc();
        mem_ready = 1; mem_rdata = 64'hAABBCCDD_11223344;
        #1;
        chk("fetch_mem_req2", mem_req, 1);
        chk("fetch_not_valid_yet", if_valid, 0);
        cyc();
        mem_ready = 0;
        #1;
        chk("fetch_valid", if_valid, 1);
        chk("fetch_rdata", if_rdata, 32'h11223344);
        chk("fetch_err", if_err, 0);
        chk("fetch_busy_done", busy, 1);
        cyc();
        #1;
        chk("fetch_valid_pulse", if_valid, 0);
        chk("fetch_rdata_clear", if_rdata, 0);
        chk("fetch_idle", busy, 0);

        // store byte 0x5A to 0x23; request inputs garbled after grant
        d_req = 1; d_we = 1; d_size = 2'd0; d_addr = 64'h23; d_wdata = 64'h5A;
        #1;
        chk("stb_gnt", d_gnt, 1);
        cyc();
        d_req = 0; d_addr = 64'hFFF; d_size = 2'd3; d_wdata = 64'hFFFF; mem_ready = 1; mem_rdata = 0;
        #1;
        chk("stb_mem_addr", mem_addr, 64'h20);
        chk("stb_mem_be", mem_be, 8'h08);
        chk("stb_mem_wdata", mem_wdata, 64'h5A00_0000);
        chk("stb_mem_we", mem_we, 1);
        cyc();
        mem_ready = 0;
        #1;
        chk("stb_valid", d_valid, 1);
        chk("stb_err", d_err, 0);

        // load half from 0x26
        cyc();
        d_req = 1; d_we = 0; d_size = 2'd1; d_addr = 64'h26;
        #1;
        chk("ldh_gnt", d_gnt, 1);
        cyc();
        d_req = 0; mem_ready = 1; mem_rdata = 64'h1234_0000_0000_0000;
        #1;
        chk("ldh_mem_be", mem_be, 8'hC0);
        chk("ldh_mem_we", mem_we, 0);
        chk("ldh_mem_addr", mem_addr, 64'h20);
        cyc();
        mem_ready = 0;
        #1;
        chk("ldh_valid", d_valid, 1);
        chk("ldh_rdata", d_rdata, 64'h1234);
        chk("ldh_err", d_err, 0);
        cyc();
        #1;
        chk("ldh_rdata_clear", d_rdata, 0);

        // misaligned word load at 0x22
        d_req = 1; d_size = 2'd2; d_addr = 64'h22;
        #1;
        chk("misw_gnt", d_gnt, 1);
        cyc();
        d_req = 0;
        #1;
        chk("misw_no_mem_req", mem_req, 0);
        chk("misw_valid", d_valid, 1);
        chk("misw_err", d_err, 1);
        chk("misw_rdata", d_rdata, 0);
        cyc();
        #1;
        chk("misw_idle", busy, 0);

        // misaligned fetch at 0x12
        if_req = 1; if_addr = 64'h12;
        #1;
        chk("misf_gnt", if_gnt, 1);
        cyc();
        if_req = 0;
        #1;
        chk("misf_no_mem_req", mem_req, 0);
        chk("misf_valid", if_valid, 1);
        chk("misf_err", if_err, 1);
        cyc();

        // timeout: aligned double load, mem_ready never rises
        d_req = 1; d_size = 2'd3; d_addr = 64'h100; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("to_gnt", d_gnt, 1);
        for (int c = 1; c <= 15; c++) begin
            cyc();
            d_req = 0;
            #1;
            chk("to_mem_req_held", mem_req, 1);
            chk("to_no_valid", d_valid, 0);
        end
        cyc();
        #1;
        chk("to_valid", d_valid, 1);
        chk("to_err", d_err, 1);
        chk("to_rdata", d_rdata, 0);
        chk("to_mem_req_drop", mem_req, 0);
        cyc();

        // reset while in ACCESS
        d_req = 1; d_we = 1; d_size = 2'd3; d_addr = 64'h200; d_wdata = 64'h1;
        #1;
        chk("rsta_gnt", d_gnt, 1);
        cyc();
        d_req = 0;
        #1;
        chk("rsta_in_access", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("rsta_mem_req", mem_req, 0);
        chk("rsta_mem_we", mem_we, 0);
        chk("rsta_mem_be", mem_be, 0);
        chk("rsta_mem_wdata", mem_wdata, 0);
        chk("rsta_busy", busy, 0);
        chk("rsta_d_valid", d_valid, 0);
        cyc();
        reset = 1'b0;
        cyc();
        #1;
        chk("rsta_no_valid", d_valid, 0);
        chk("rsta_still_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
